// File: rtl/keypad_pkg.sv
// Shared types, constants and helpers for the 4x4 keypad scan controller
// and the calculator input FSM that consumes its key codes.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } kp_state_t;

    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 4;

    // Key code = {row_idx, col_idx}; physical layout of the calculator keypad.
    localparam logic [3:0] KEY_1    = 4'h0;
    localparam logic [3:0] KEY_2    = 4'h1;
    localparam logic [3:0] KEY_3    = 4'h2;
    localparam logic [3:0] KEY_A    = 4'h3;
    localparam logic [3:0] KEY_4    = 4'h4;
    localparam logic [3:0] KEY_5    = 4'h5;
    localparam logic [3:0] KEY_6    = 4'h6;
    localparam logic [3:0] KEY_B    = 4'h7;
    localparam logic [3:0] KEY_7    = 4'h8;
    localparam logic [3:0] KEY_8    = 4'h9;
    localparam logic [3:0] KEY_9    = 4'hA;
    localparam logic [3:0] KEY_C    = 4'hB;
    localparam logic [3:0] KEY_STAR = 4'hC;
    localparam logic [3:0] KEY_0    = 4'hD;
    localparam logic [3:0] KEY_HASH = 4'hE;
    localparam logic [3:0] KEY_D    = 4'hF;

    // Pack a row/column pair into the 4-bit key code.
    function automatic logic [3:0] kp_encode(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

    // Index of the lowest asserted row; row 0 wins when several are active.
    function automatic logic [1:0] kp_lowest_row(input logic [KP_ROWS-1:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = KP_ROWS - 1; i >= 0; i--) begin
            if (rows[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_debounce.sv
// Per-bit debouncer: two-flop synchronizer followed by a counter that only
// accepts a new level after THRESH consecutive differing samples.
// Deliberately has no reset; the scan dwell time covers its settling.
module debounce #(
    parameter int WIDTH  = 4,
    parameter int THRESH = 3
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] stable
);

    localparam int CNT_W = $clog2(THRESH + 1);

    logic [WIDTH-1:0] sync1_reg;
    logic [WIDTH-1:0] sync2_reg;

    // Bring the asynchronous pins into the clock domain.
    always_ff @(posedge clk) begin
        sync1_reg <= raw;
        sync2_reg <= sync1_reg;
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [CNT_W-1:0] cnt_reg;
            logic             out_reg;

            // Count consecutive samples that disagree with the accepted level;
            // >= keeps an arbitrary power-up count from getting stuck.
            always_ff @(posedge clk) begin
                if (sync2_reg[gi] == out_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg >= CNT_W'(THRESH - 1)) begin
                    out_reg <= sync2_reg[gi];
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end

            assign stable[gi] = out_reg;
        end
    endgenerate

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: walks the columns one-hot, evaluates debounced rows at
// the end of each dwell window and emits one key event per press over a
// valid/ready handshake, flagging presses lost to a busy consumer.
module keypad_scan_ctrl #(
    parameter int DB_THRESH = 3,
    parameter int DWELL     = 8,
    parameter int GAP       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_raw,
    output logic [3:0] col_drv,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    input  logic       clr_overrun,
    output logic       overrun,
    output logic       key_held
);

    import keypad_pkg::*;

    localparam int CNT_MAX = (DWELL > GAP) ? DWELL : GAP;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);

    localparam logic [1:0] ST_SCAN = keypad_pkg::SCAN;
    localparam logic [1:0] ST_HOLD = keypad_pkg::HOLD;
    localparam logic [1:0] ST_GAP  = keypad_pkg::GAP;

    // The dwell must outlast the debouncer latency, or rows from the previous
    // column could still be visible when this column is evaluated.
    generate
        if (DWELL < DB_THRESH + 4) begin : g_dwell_check
            $error("keypad_scan_ctrl: DWELL must be >= DB_THRESH+4");
        end
    endgenerate

    logic [1:0]       state_reg,     state_next;
    logic [1:0]       col_idx_reg,   col_idx_next;
    logic [CNT_W-1:0] dwell_cnt_reg, dwell_cnt_next;
    logic [3:0]       key_code_reg,  key_code_next;
    logic             key_valid_reg, key_valid_next;
    logic             overrun_reg,   overrun_next;

    logic [KP_ROWS-1:0] row_db;
    logic [1:0]         row_idx;
    logic               event_fire;
    logic               overrun_set;

    debounce #(
        .WIDTH  (KP_ROWS),
        .THRESH (DB_THRESH)
    ) u_debounce (
        .clk    (clk),
        .raw    (row_raw),
        .stable (row_db)
    );

    assign row_idx = kp_lowest_row(row_db);

    // Scan FSM, event capture and sticky overrun next-state logic.
    always_comb begin
        state_next     = state_reg;
        col_idx_next   = col_idx_reg;
        dwell_cnt_next = dwell_cnt_reg;
        key_code_next  = key_code_reg;
        key_valid_next = key_valid_reg;
        overrun_next   = overrun_reg;
        event_fire     = 1'b0;
        overrun_set    = 1'b0;

        case (state_reg)
            ST_SCAN: begin
                if (dwell_cnt_reg == DWELL_LAST) begin
                    if (row_db == '0) begin
                        col_idx_next   = col_idx_reg + 2'd1;
                        dwell_cnt_next = '0;
                    end else begin
                        state_next = ST_HOLD;
                        event_fire = 1'b1;
                    end
                end else begin
                    dwell_cnt_next = dwell_cnt_reg + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (row_db == '0) begin
                    state_next     = ST_GAP;
                    dwell_cnt_next = '0;
                end
            end
            ST_GAP: begin
                if (row_db != '0) begin
                    dwell_cnt_next = '0;
                end else if (dwell_cnt_reg == GAP_LAST) begin
                    col_idx_next   = col_idx_reg + 2'd1;
                    dwell_cnt_next = '0;
                    state_next     = ST_SCAN;
                end else begin
                    dwell_cnt_next = dwell_cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next     = ST_SCAN;
                dwell_cnt_next = '0;
            end
        endcase

        // Consumer handshake retires the pending event.
        if (key_valid_reg && key_ready) begin
            key_valid_next = 1'b0;
        end

        // A new press loads only if the slot is free or being freed this cycle.
        if (event_fire) begin
            if (!key_valid_reg || key_ready) begin
                key_code_next  = kp_encode(row_idx, col_idx_reg);
                key_valid_next = 1'b1;
            end else begin
                overrun_set = 1'b1;
            end
        end

        // Set takes priority over clear so a drop is never lost.
        if (overrun_set) begin
            overrun_next = 1'b1;
        end else if (clr_overrun) begin
            overrun_next = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_SCAN;
            col_idx_reg   <= 2'd0;
            dwell_cnt_reg <= '0;
            key_code_reg  <= 4'd0;
            key_valid_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            col_idx_reg   <= col_idx_next;
            dwell_cnt_reg <= dwell_cnt_next;
            key_code_reg  <= key_code_next;
            key_valid_reg <= key_valid_next;
            overrun_reg   <= overrun_next;
        end
    end

    assign col_drv   = 4'b0001 << col_idx_reg;
    assign key_code  = key_code_reg;
    assign key_valid = key_valid_reg;
    assign overrun   = overrun_reg;
    assign key_held  = (state_reg == ST_HOLD);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a behavioural keypad matrix model.
module tb_keypad_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row_raw;
    logic [3:0] col_drv;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       clr_overrun;
    logic       overrun;
    logic       key_held;

    logic [15:0] pressed;   // bit r*4+c = key at row r, column c held down
    logic [3:0]  glitch;    // forced row noise independent of the columns

    int n_checks = 0;
    int n_pass   = 0;
    bit ok;
    int n;
    int bad;
    logic [3:0] c0;

    always #5 clk = ~clk;

    keypad_scan_ctrl #(
        .DB_THRESH (3),
        .DWELL     (8),
        .GAP       (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .row_raw     (row_raw),
        .col_drv     (col_drv),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .clr_overrun (clr_overrun),
        .overrun     (overrun),
        .key_held    (key_held)
    );

    // Matrix model: a pressed key connects its row to its driven column.
    always_comb begin
        row_raw = glitch;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && col_drv[c]) begin
                    row_raw[r] = 1'b1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic wait_valid(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (key_valid) begin
                found = 1'b1;
                $display("event key_code=%b overrun=%0b t=%0t", key_code, overrun, $time);
                break;
            end
        end
    endtask

    task automatic wait_held(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (key_held) begin
                found = 1'b1;
                $display("hold key_code=%b key_valid=%0b overrun=%0b t=%0t",
                         key_code, key_valid, overrun, $time);
                break;
            end
        end
    endtask

    task automatic wait_col_change(input int budget, output bit found);
        logic [3:0] prev;
        prev  = col_drv;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (col_drv != prev) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic count_events(input int cycles, output int events);
        logic prev;
        prev   = key_valid;
        events = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (key_valid && !prev) begin
                events++;
                $display("event key_code=%b t=%0t", key_code, $time);
            end
            prev = key_valid;
        end
    endtask

    initial begin
        rst         = 1'b1;
        pressed     = '0;
        glitch      = '0;
        key_ready   = 1'b1;
        clr_overrun = 1'b0;

        // Reset for two edges, then idle column walk.
        tick(2);
        check("rst_col_drv",   col_drv,   4'b0001);
        check("rst_key_code",  key_code,  4'd0);
        check("rst_key_valid", key_valid, 1'b0);
        check("rst_overrun",   overrun,   1'b0);
        check("rst_key_held",  key_held,  1'b0);
        rst = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            logic [3:0] exp_col;
            @(negedge clk);
            exp_col = 4'b0001 << ((k / 8) % 4);
            check($sformatf("idle_col_k%0d", k), col_drv, exp_col);
        end
        $display("scan idle walk done t=%0t", $time);

        // Single press row2/col1, consumer always ready.
        pressed[2*4+1] = 1'b1;
        wait_valid(100, ok);
        check("t1_found",    ok,       1'b1);
        check("t1_code",     key_code, 4'b1001);
        check("t1_held",     key_held, 1'b1);
        tick(1);
        check("t1_pulse",    key_valid, 1'b0);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!key_held || key_valid) bad++;
        end
        check("t1_hold_steady", bad, 0);
        pressed[2*4+1] = 1'b0;
        tick(3);
        pressed[2*4+1] = 1'b1;
        tick(2);
        pressed[2*4+1] = 1'b0;
        tick(6);
        pressed[2*4+1] = 1'b1;
        tick(2);
        pressed[2*4+1] = 1'b0;
        count_events(120, n);
        check("t1_no_retrigger", n, 0);
        check("t1_released",     key_held, 1'b0);

        // Overrun: consumer stalled, second press dropped.
        key_ready = 1'b0;
        pressed[1*4+3] = 1'b1;
        wait_valid(100, ok);
        check("t2_found", ok,       1'b1);
        check("t2_code",  key_code, 4'b0111);
        pressed[1*4+3] = 1'b0;
        tick(40);
        check("t2_pending_valid", key_valid, 1'b1);
        check("t2_pending_code",  key_code,  4'b0111);
        check("t2_no_overrun",    overrun,   1'b0);
        pressed[0*4+0] = 1'b1;
        wait_held(100, ok);
        check("t2_second_held", ok,        1'b1);
        check("t2_overrun",     overrun,   1'b1);
        check("t2_code_kept",   key_code,  4'b0111);
        check("t2_valid_kept",  key_valid, 1'b1);
        pressed[0*4+0] = 1'b0;
        tick(40);
        check("t2_overrun_sticky", overrun,  1'b1);
        check("t2_back_to_scan",   key_held, 1'b0);
        key_ready   = 1'b1;
        clr_overrun = 1'b1;
        tick(1);
        clr_overrun = 1'b0;
        check("t2_consumed", key_valid, 1'b0);
        check("t2_cleared",  overrun,   1'b0);

        // Two rows on column 2: row 1 has priority, one event only.
        pressed[1*4+2] = 1'b1;
        pressed[3*4+2] = 1'b1;
        wait_valid(100, ok);
        check("t3_found", ok,       1'b1);
        check("t3_code",  key_code, 4'b0110);
        tick(1);
        check("t3_pulse", key_valid, 1'b0);
        tick(5);
        pressed = '0;
        count_events(80, n);
        check("t3_single_event", n, 0);

        // Two-cycle row glitch near the end of a window: no event, no stall.
        wait_col_change(40, ok);
        check("t4_sync", ok, 1'b1);
        c0  = col_drv;
        bad = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (key_valid || key_held) bad++;
            if (k == 7) check("t4_col_hold", col_drv, c0);
            if (k == 8) check("t4_col_next", col_drv, {c0[2:0], c0[3]});
            if (k == 2) glitch = 4'b0100;
            if (k == 4) glitch = 4'b0000;
        end
        check("t4_no_event", bad, 0);
        count_events(40, n);
        check("t4_quiet", n, 0);

        // Reset during HOLD with an event pending, key still held down.
        key_ready = 1'b0;
        pressed[2*4+3] = 1'b1;
        wait_valid(100, ok);
        check("t5_found", ok,       1'b1);
        check("t5_code",  key_code, 4'b1011);
        tick(2);
        check("t5_in_hold", key_held, 1'b1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t5_rst_valid", key_valid, 1'b0);
        check("t5_rst_col",   col_drv,   4'b0001);
        check("t5_rst_held",  key_held,  1'b0);
        check("t5_rst_code",  key_code,  4'd0);
        wait_valid(100, ok);
        check("t5_redetect",      ok,       1'b1);
        check("t5_redetect_code", key_code, 4'b1011);
        check("t5_redetect_held", key_held, 1'b1);
        pressed   = '0;
        key_ready = 1'b1;
        tick(30);
        check("t5_final_idle", key_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
